// File: rtl/sd_cmd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sd_cmd_arbiter_pkg
// Shared definitions for the SD command arbiter slice:
//   - one-hot state encoding of the arbitration FSM
//   - NORMAL_INT bit positions the arbiter's status inputs are taken from
//   - requester index names (host, auto-CMD12, init sequencer)
//   - payload field widths and the round-robin pointer advance helper
// ---------------------------------------------------------------------------
package sd_cmd_arbiter_pkg;

    // One-hot FSM encoding; each state owns exactly one flop bit.
    typedef enum logic [5:0] {
        ST_IDLE       = 6'b000001,
        ST_ISSUE      = 6'b000010,
        ST_WAIT_START = 6'b000100,
        ST_BUSY       = 6'b001000,
        ST_DONE       = 6'b010000,
        ST_CLEAR      = 6'b100000
    } arb_state_e;

    // NORMAL_INT bit positions of the command master.
    localparam int NI_CC_BIT   = 0;
    localparam int NI_CARD_BIT = 1;
    localparam int NI_EI_BIT   = 15;

    // Requester slots, lowest index has the first turn after reset.
    localparam int REQ_HOST   = 0;
    localparam int REQ_ACMD12 = 1;
    localparam int REQ_INIT   = 2;

    // Payload and status field widths.
    localparam int ARG_W  = 32;
    localparam int CMD_W  = 14;
    localparam int TMO_W  = 16;
    localparam int ERR_W  = 5;
    localparam int RESP_W = 32;

    // Round-robin pointer advance: the slot after the winner, with wrap.
    function automatic int next_ptr(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sd_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// sd_cmd_arbiter_if
// Bundle between the arbiter and the SD command master.
//   master modport (arbiter side):
//     out new_cmd, arg, cmd_set, tmo, int_rst
//     in  card_present, cicmd, cc, ei, err_int, resp
//   slave modport (command master side): the same signals, reversed.
// int_rst drives both ERR_INT_RST and NORMAL_INT_RST of the master.
// ---------------------------------------------------------------------------
interface sd_cmd_arbiter_if;
    import sd_cmd_arbiter_pkg::*;

    logic              new_cmd;
    logic [ARG_W-1:0]  arg;
    logic [CMD_W-1:0]  cmd_set;
    logic [TMO_W-1:0]  tmo;
    logic              int_rst;
    logic              card_present;
    logic              cicmd;
    logic              cc;
    logic              ei;
    logic [ERR_W-1:0]  err_int;
    logic [RESP_W-1:0] resp;

    modport master (
        output new_cmd, arg, cmd_set, tmo, int_rst,
        input  card_present, cicmd, cc, ei, err_int, resp
    );

    modport slave (
        input  new_cmd, arg, cmd_set, tmo, int_rst,
        output card_present, cicmd, cc, ei, err_int, resp
    );

endinterface

// File: rtl/sd_cmd_arbiter_rr.sv
// ---------------------------------------------------------------------------
// sd_rr_arbiter
// Purely combinational round-robin picker. The winner is the first set
// request bit at or above ptr_i, searching upward and wrapping to 0.
//   req_i  in  NREQ   request vector
//   ptr_i  in  IDX_W  slot with the highest priority this round
//   gnt_o  out NREQ   one-hot winner (all zero when req_i is zero)
//   idx_o  out IDX_W  encoded winner index
// ---------------------------------------------------------------------------
module sd_rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    // Walk the slots starting at the pointer; the first hit wins and
    // masks every later candidate through the found flag.
    always_comb begin
        logic found;
        int   slot;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        slot  = 0;
        for (int off = 0; off < NREQ; off++) begin
            slot = int'(ptr_i) + off;
            if (slot >= NREQ) begin
                slot = slot - NREQ;
            end
            if (!found && req_i[slot]) begin
                found       = 1'b1;
                gnt_o[slot] = 1'b1;
                idx_o       = IDX_W'(slot);
            end
        end
    end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// sd_cmd_arbiter
// Shares one SD command master among NREQ requesters with round-robin
// priority. A grant is held from the New_CMD pulse until the master reports
// completion or error and has dropped both flags again; the winner gets the
// captured response/error and a done pulse. A guard counter forces the
// transaction to end (abort_o) when the master never finishes.
//   CLK_PAD_IO      in   system clock
//   RST_PAD_NI      in   asynchronous active-low reset
//   req_i           in   per-requester request level
//   req_arg_i       in   packed arguments, slot k at [32k+31:32k]
//   req_cmd_i       in   packed CMD_SET values, slot k at [14k+13:14k]
//   req_tmo_i       in   packed timeout values, slot k at [16k+15:16k]
//   gnt_o           out  one-hot grant, held for the whole transaction
//   done_o          out  one-hot completion pulse
//   resp_o/err_o    out  captured RESP_1 / ERR_INT, valid with done_o
//   abort_o         out  guard timeout flag, valid with done_o
//   cmd_if          master side of the command master bundle
// ---------------------------------------------------------------------------
module sd_cmd_arbiter
    import sd_cmd_arbiter_pkg::*;
#(
    parameter int                 NREQ      = 3,
    parameter int                 GUARD_W   = 20,
    parameter logic [GUARD_W-1:0] GUARD_CYC = 20'hFFFFF
) (
    input  logic                    CLK_PAD_IO,
    input  logic                    RST_PAD_NI,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*ARG_W-1:0]   req_arg_i,
    input  logic [NREQ*CMD_W-1:0]   req_cmd_i,
    input  logic [NREQ*TMO_W-1:0]   req_tmo_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [NREQ-1:0]         done_o,
    output logic [RESP_W-1:0]       resp_o,
    output logic [ERR_W-1:0]        err_o,
    output logic                    abort_o,
    sd_cmd_arbiter_if.master        cmd_if
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Guard fires on the edge where the count would reach GUARD_CYC, so the
    // forced DONE shows up exactly GUARD_CYC cycles after WAIT_START starts.
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_CYC - 1'b1;

    arb_state_e          state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [ARG_W-1:0]    arg_q, arg_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [GUARD_W-1:0]  guard_q, guard_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                abort_q, abort_d;

    logic                new_cmd_c;
    logic                int_rst_c;
    logic [NREQ-1:0]     done_c;
    logic                finish_c;
    logic                abort_c;

    logic [NREQ-1:0]     rr_gnt;
    logic [IDX_W-1:0]    rr_idx;

    sd_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx)
    );

    // Next-state and pulse outputs. Every transaction-ending path (normal
    // completion, error, guard expiry) funnels through finish_c so the
    // response capture happens in one place, on the edge entering DONE.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        arg_d     = arg_q;
        cmd_d     = cmd_q;
        tmo_d     = tmo_q;
        guard_d   = guard_q;
        resp_d    = resp_q;
        err_d     = err_q;
        abort_d   = abort_q;
        new_cmd_c = 1'b0;
        int_rst_c = 1'b0;
        done_c    = '0;
        finish_c  = 1'b0;
        abort_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_if.card_present && (req_i != '0)) begin
                    gnt_d   = rr_gnt;
                    idx_d   = rr_idx;
                    arg_d   = req_arg_i[int'(rr_idx)*ARG_W +: ARG_W];
                    cmd_d   = req_cmd_i[int'(rr_idx)*CMD_W +: CMD_W];
                    tmo_d   = req_tmo_i[int'(rr_idx)*TMO_W +: TMO_W];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                new_cmd_c = 1'b1;
                guard_d   = '0;
                state_d   = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                guard_d = guard_q + 1'b1;
                if (guard_q == GUARD_LAST) begin
                    finish_c = 1'b1;
                    abort_c  = 1'b1;
                end else if (cmd_if.cicmd) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                guard_d = guard_q + 1'b1;
                if (cmd_if.cc || cmd_if.ei) begin
                    finish_c = 1'b1;
                end else if (guard_q == GUARD_LAST) begin
                    finish_c = 1'b1;
                    abort_c  = 1'b1;
                end
            end
            ST_DONE: begin
                done_c    = gnt_q;
                int_rst_c = 1'b1;
                ptr_d     = IDX_W'(next_ptr(int'(idx_q), NREQ));
                state_d   = ST_CLEAR;
            end
            ST_CLEAR: begin
                // Hold the grant until the master's interrupt flags are
                // actually gone, so the next winner never sees stale status.
                if (!cmd_if.cc && !cmd_if.ei) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish_c) begin
            state_d = ST_DONE;
            resp_d  = cmd_if.resp;
            err_d   = cmd_if.err_int;
            abort_d = abort_c;
        end
    end

    // State and datapath registers; reset clears everything at once, so a
    // transaction interrupted by reset never produces a done pulse.
    always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_NI) begin
        if (!RST_PAD_NI) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            arg_q   <= '0;
            cmd_q   <= '0;
            tmo_q   <= '0;
            guard_q <= '0;
            resp_q  <= '0;
            err_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            arg_q   <= arg_d;
            cmd_q   <= cmd_d;
            tmo_q   <= tmo_d;
            guard_q <= guard_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    assign cmd_if.new_cmd = new_cmd_c;
    assign cmd_if.int_rst = int_rst_c;
    assign cmd_if.arg     = arg_q;
    assign cmd_if.cmd_set = cmd_q;
    assign cmd_if.tmo     = tmo_q;

    assign gnt_o   = gnt_q;
    assign done_o  = done_c;
    assign resp_o  = resp_q;
    assign err_o   = err_q;
    assign abort_o = abort_q;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_arbiter
// Self-checking bench for sd_cmd_arbiter: a per-cycle vector table for two
// complete transactions, followed by hand-written sequences for round-robin
// rotation, guard timeout, card absence and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_sd_cmd_arbiter;
    import sd_cmd_arbiter_pkg::*;

    localparam int NREQ = 3;

    logic clk = 1'b0;
    logic rstN;

    logic [NREQ-1:0]       req;
    logic [NREQ*ARG_W-1:0] reqArg;
    logic [NREQ*CMD_W-1:0] reqCmd;
    logic [NREQ*TMO_W-1:0] reqTmo;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [RESP_W-1:0]     respOut;
    logic [ERR_W-1:0]      errOut;
    logic                  abortOut;

    int testsRun    = 0;
    int testsFailed = 0;

    // Expected per-requester payloads, written independently of reqArg/etc.
    logic [ARG_W-1:0] argOf [NREQ];
    logic [CMD_W-1:0] cmdOf [NREQ];
    logic [TMO_W-1:0] tmoOf [NREQ];

    sd_cmd_arbiter_if cmdIf ();

    sd_cmd_arbiter #(
        .NREQ      (NREQ),
        .GUARD_W   (20),
        .GUARD_CYC (20'd100)
    ) dut (
        .CLK_PAD_IO (clk),
        .RST_PAD_NI (rstN),
        .req_i      (req),
        .req_arg_i  (reqArg),
        .req_cmd_i  (reqCmd),
        .req_tmo_i  (reqTmo),
        .gnt_o      (gnt),
        .done_o     (done),
        .resp_o     (respOut),
        .err_o      (errOut),
        .abort_o    (abortOut),
        .cmd_if     (cmdIf)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [2:0]  req;
        logic        card;
        logic        cicmd;
        logic        cc;
        logic        ei;
        logic [4:0]  errIn;
        logic [31:0] respIn;
        logic [2:0]  expGnt;
        logic        expNew;
        logic [2:0]  expDone;
        logic        expIntRst;
        int          expIdx;
        logic [31:0] expResp;
        logic [4:0]  expErr;
        logic        expAbort;
    } vector_t;

    localparam int NVEC = 13;
    vector_t vecs [NVEC];

    // One comparison: counts it, and reports it when it does not match.
    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Status flags go through a NORMAL_INT image so the bit mapping is used.
    task automatic setMasterFlags(input logic cc, input logic card, input logic ei);
        logic [15:0] normalInt;
        normalInt              = '0;
        normalInt[NI_CC_BIT]   = cc;
        normalInt[NI_CARD_BIT] = card;
        normalInt[NI_EI_BIT]   = ei;
        cmdIf.cc               = normalInt[NI_CC_BIT];
        cmdIf.card_present     = normalInt[NI_CARD_BIT];
        cmdIf.ei               = normalInt[NI_EI_BIT];
    endtask

    task automatic applyStimulus(input vector_t v);
        req           = v.req;
        cmdIf.cicmd   = v.cicmd;
        cmdIf.err_int = v.errIn;
        cmdIf.resp    = v.respIn;
        setMasterFlags(v.cc, v.card, v.ei);
    endtask

    task automatic checkOutput(input vector_t v, input int n);
        checkField($sformatf("vec%0d.gnt", n), 32'(gnt), 32'(v.expGnt));
        checkField($sformatf("vec%0d.new_cmd", n), 32'(cmdIf.new_cmd), 32'(v.expNew));
        checkField($sformatf("vec%0d.done", n), 32'(done), 32'(v.expDone));
        checkField($sformatf("vec%0d.int_rst", n), 32'(cmdIf.int_rst), 32'(v.expIntRst));
        checkField($sformatf("vec%0d.arg", n), cmdIf.arg, argOf[v.expIdx]);
        checkField($sformatf("vec%0d.cmd_set", n), 32'(cmdIf.cmd_set), 32'(cmdOf[v.expIdx]));
        checkField($sformatf("vec%0d.tmo", n), 32'(cmdIf.tmo), 32'(tmoOf[v.expIdx]));
        checkField($sformatf("vec%0d.resp", n), respOut, v.expResp);
        checkField($sformatf("vec%0d.err", n), 32'(errOut), 32'(v.expErr));
        checkField($sformatf("vec%0d.abort", n), 32'(abortOut), 32'(v.expAbort));
    endtask

    task automatic checkAllZero(input string tag);
        checkField({tag, ".gnt"}, 32'(gnt), 32'd0);
        checkField({tag, ".done"}, 32'(done), 32'd0);
        checkField({tag, ".new_cmd"}, 32'(cmdIf.new_cmd), 32'd0);
        checkField({tag, ".int_rst"}, 32'(cmdIf.int_rst), 32'd0);
        checkField({tag, ".arg"}, cmdIf.arg, 32'd0);
        checkField({tag, ".cmd_set"}, 32'(cmdIf.cmd_set), 32'd0);
        checkField({tag, ".tmo"}, 32'(cmdIf.tmo), 32'd0);
        checkField({tag, ".resp"}, respOut, 32'd0);
        checkField({tag, ".err"}, 32'(errOut), 32'd0);
        checkField({tag, ".abort"}, 32'(abortOut), 32'd0);
    endtask

    task automatic clearInputs();
        req           = '0;
        cmdIf.cicmd   = 1'b0;
        cmdIf.err_int = '0;
        cmdIf.resp    = '0;
        setMasterFlags(1'b0, 1'b1, 1'b0);
    endtask

    task automatic doReset(input string tag);
        @(posedge clk); #1;
        rstN = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        checkAllZero(tag);
        rstN = 1'b1;
    endtask

    // Bounded wait for the New_CMD pulse; leaves time at posedge+1.
    task automatic waitNewCmd(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk); #1;
            ok = cmdIf.new_cmd;
        end
    endtask

    // One full transaction with a well-behaved master, checking the winner.
    task automatic doTransaction(input string tag, input int k);
        bit ok;
        logic [2:0] expGnt;
        expGnt = 3'b001 << k;
        waitNewCmd(ok);
        checkField({tag, ".new_cmd_seen"}, 32'(ok), 32'd1);
        checkField({tag, ".gnt"}, 32'(gnt), 32'(expGnt));
        checkField({tag, ".arg"}, cmdIf.arg, argOf[k]);
        checkField({tag, ".cmd_set"}, 32'(cmdIf.cmd_set), 32'(cmdOf[k]));
        cmdIf.cicmd = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmdIf.cicmd = 1'b0;
        cmdIf.resp  = argOf[k] ^ 32'hFFFF_0000;
        setMasterFlags(1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkField({tag, ".done"}, 32'(done), 32'(expGnt));
        checkField({tag, ".int_rst"}, 32'(cmdIf.int_rst), 32'd1);
        checkField({tag, ".resp"}, respOut, argOf[k] ^ 32'hFFFF_0000);
        setMasterFlags(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bit ok;
        int cnt;
        int rrOrder [4];

        argOf[REQ_HOST]   = 32'h0000_01AA;
        argOf[REQ_ACMD12] = 32'h0000_0C0C;
        argOf[REQ_INIT]   = 32'hAAAA_0002;
        cmdOf[REQ_HOST]   = 14'h0819;
        cmdOf[REQ_ACMD12] = 14'h0C1B;
        cmdOf[REQ_INIT]   = 14'h0002;
        tmoOf[REQ_HOST]   = 16'h0100;
        tmoOf[REQ_ACMD12] = 16'h0200;
        tmoOf[REQ_INIT]   = 16'h0300;
        reqArg = {32'hAAAA_0002, 32'h0000_0C0C, 32'h0000_01AA};
        reqCmd = {14'h0002, 14'h0C1B, 14'h0819};
        reqTmo = {16'h0300, 16'h0200, 16'h0100};

        // req card cicmd cc ei errIn respIn | gnt new done irst idx resp err abort
        vecs[0]  = '{3'b001, 1, 0, 0, 0, 5'd0, 32'h0, 3'b001, 1, 3'b000, 0, REQ_HOST, 32'h0, 5'd0, 0};
        vecs[1]  = '{3'b000, 1, 1, 0, 0, 5'd0, 32'h0, 3'b001, 0, 3'b000, 0, REQ_HOST, 32'h0, 5'd0, 0};
        vecs[2]  = '{3'b000, 1, 1, 0, 0, 5'd0, 32'h0, 3'b001, 0, 3'b000, 0, REQ_HOST, 32'h0, 5'd0, 0};
        vecs[3]  = '{3'b000, 1, 0, 1, 0, 5'd0, 32'h0000_01AA, 3'b001, 0, 3'b001, 1, REQ_HOST, 32'h0000_01AA, 5'd0, 0};
        vecs[4]  = '{3'b000, 1, 0, 1, 0, 5'd0, 32'h0000_01AA, 3'b001, 0, 3'b000, 0, REQ_HOST, 32'h0000_01AA, 5'd0, 0};
        vecs[5]  = '{3'b000, 1, 0, 0, 0, 5'd0, 32'h0, 3'b000, 0, 3'b000, 0, REQ_HOST, 32'h0000_01AA, 5'd0, 0};
        vecs[6]  = '{3'b010, 1, 0, 0, 0, 5'd0, 32'h0, 3'b010, 1, 3'b000, 0, REQ_ACMD12, 32'h0000_01AA, 5'd0, 0};
        vecs[7]  = '{3'b000, 1, 1, 0, 0, 5'd0, 32'h0, 3'b010, 0, 3'b000, 0, REQ_ACMD12, 32'h0000_01AA, 5'd0, 0};
        vecs[8]  = '{3'b000, 1, 1, 0, 0, 5'd0, 32'h0, 3'b010, 0, 3'b000, 0, REQ_ACMD12, 32'h0000_01AA, 5'd0, 0};
        vecs[9]  = '{3'b000, 1, 0, 1, 1, 5'b00010, 32'hDEAD_BEEF, 3'b010, 0, 3'b010, 1, REQ_ACMD12, 32'hDEAD_BEEF, 5'b00010, 0};
        vecs[10] = '{3'b000, 1, 0, 1, 1, 5'b00010, 32'hDEAD_BEEF, 3'b010, 0, 3'b000, 0, REQ_ACMD12, 32'hDEAD_BEEF, 5'b00010, 0};
        vecs[11] = '{3'b000, 1, 0, 0, 1, 5'b00010, 32'hDEAD_BEEF, 3'b010, 0, 3'b000, 0, REQ_ACMD12, 32'hDEAD_BEEF, 5'b00010, 0};
        vecs[12] = '{3'b000, 1, 0, 0, 0, 5'd0, 32'h0, 3'b000, 0, 3'b000, 0, REQ_ACMD12, 32'hDEAD_BEEF, 5'b00010, 0};

        rstN = 1'b0;
        clearInputs();
        doReset("reset");

        // Host transaction, then an error completion with cc and ei together.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk); #1;
            checkOutput(vecs[i], i);
        end

        // Round-robin rotation with every requester held from ptr = 0.
        doReset("rr_reset");
        rrOrder = '{REQ_HOST, REQ_ACMD12, REQ_INIT, REQ_HOST};
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            doTransaction($sformatf("rr%0d", i), rrOrder[i]);
        end
        req = 3'b000;
        repeat (3) @(posedge clk);
        #1;

        // Guard timeout: master never raises cicmd (ptr = 1 here).
        req = 3'b010;
        waitNewCmd(ok);
        checkField("guard.new_cmd_seen", 32'(ok), 32'd1);
        checkField("guard.gnt", 32'(gnt), 32'b010);
        req           = 3'b000;
        cmdIf.resp    = 32'h1234_5678;
        cmdIf.err_int = 5'b00100;
        @(posedge clk); #1;
        cnt = 0;
        while (done == '0 && cnt < 150) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkField("guard.cycles", 32'(cnt), 32'd100);
        checkField("guard.done", 32'(done), 32'b010);
        checkField("guard.abort", 32'(abortOut), 32'd1);
        checkField("guard.resp", respOut, 32'h1234_5678);
        checkField("guard.err", 32'(errOut), 32'b00100);
        cmdIf.resp    = '0;
        cmdIf.err_int = '0;
        @(posedge clk); #1;
        checkField("guard.abort_hold", 32'(abortOut), 32'd1);
        @(posedge clk); #1;

        // No grants while the card is absent; grant on the edge it returns.
        setMasterFlags(1'b0, 1'b0, 1'b0);
        req = 3'b100;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkField($sformatf("nocard%0d.gnt_new", i), 32'({gnt, cmdIf.new_cmd}), 32'd0);
        end
        setMasterFlags(1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkField("card.gnt", 32'(gnt), 32'b100);
        checkField("card.new_cmd", 32'(cmdIf.new_cmd), 32'd1);
        checkField("card.arg", cmdIf.arg, argOf[REQ_INIT]);
        req         = 3'b000;
        cmdIf.cicmd = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        setMasterFlags(1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkField("card_removed.gnt_held", 32'(gnt), 32'b100);

        // Asynchronous reset in BUSY, away from any clock edge.
        #2;
        rstN = 1'b0;
        #1;
        checkAllZero("async_reset");
        clearInputs();
        req = 3'b101;
        @(posedge clk); #1;
        rstN = 1'b1;
        waitNewCmd(ok);
        checkField("post_reset.new_cmd_seen", 32'(ok), 32'd1);
        checkField("post_reset.gnt", 32'(gnt), 32'b001);
        checkField("post_reset.arg", cmdIf.arg, argOf[REQ_HOST]);
        req = 3'b000;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
